// File: rtl/ftq_gen2.sv
// ftq_gen2: fetch target queue linking BPU predictions to icache fetch, predecode redirect,
// backend flush/commit and redirect-driven BPU update on retirement.
module ftq_gen2 #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 64,
  parameter int RD_PORTS = 2,
  parameter int CMT_W    = 2,
  localparam int IDX_W   = $clog2(DEPTH)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enq_vld,
  output logic                               enq_rdy,
  input  logic [ADDR_W-1:0]                  enq_start,
  input  logic [ADDR_W-1:0]                  enq_next,
  output logic                               fetch_vld,
  input  logic                               fetch_rdy,
  output logic [IDX_W-1:0]                   fetch_idx,
  output logic [ADDR_W-1:0]                  fetch_start,
  output logic [ADDR_W-1:0]                  fetch_next,
  input  logic                               redir_vld,
  input  logic [IDX_W-1:0]                   redir_idx,
  input  logic [ADDR_W-1:0]                  redir_npc,
  input  logic                               flush_vld,
  input  logic                               cmt_vld,
  input  logic [IDX_W:0]                     cmt_ptr_in,
  output logic                               upd_vld,
  input  logic                               upd_rdy,
  output logic [ADDR_W-1:0]                  upd_start,
  output logic [ADDR_W-1:0]                  upd_next,
  input  logic [RD_PORTS-1:0][IDX_W-1:0]     rd_idx,
  output logic [RD_PORTS-1:0][ADDR_W-1:0]    rd_next,
  output logic [IDX_W:0]                     count
);
  localparam int P_W = IDX_W + 1;
  logic [1:0] rst_sync_q, rst_sync_d;
  logic rst_n;
  logic [ADDR_W-1:0] start_q [DEPTH];
  logic [ADDR_W-1:0] start_d [DEPTH];
  logic [ADDR_W-1:0] next_q [DEPTH];
  logic [ADDR_W-1:0] next_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d, redir_q, redir_d;
  logic [IDX_W:0] tail_q, tail_d, fetch_q, fetch_d, head_q, head_d, thre_q, thre_d, count_q, count_d;
  logic [RD_PORTS-1:0][ADDR_W-1:0] rd_next_q, rd_next_d;
  logic full, enq_fire, bypass, fetch_fire, upd_fire, stop;
  logic [IDX_W:0] redir_ptr, avail, win, k, adv, cmt_span, tail_span;
  logic [IDX_W-1:0] upd_idx;

  function automatic logic in_rng(input logic [IDX_W:0] base, lo, hi, input logic [IDX_W-1:0] i);
    logic [IDX_W:0] di;
    di = {1'b0, i - base[IDX_W-1:0]};
    return ((lo - base) <= di) && (di < (hi - base));
  endfunction

  // Async assert, release aligned to clk through two stages.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  always_ff @(posedge clk or negedge rst)
    if (!rst) rst_sync_q <= '0;
    else rst_sync_q <= rst_sync_d;
  assign rst_n = rst_sync_q[1];

  assign full        = (tail_q[IDX_W] != head_q[IDX_W]) && (tail_q[IDX_W-1:0] == head_q[IDX_W-1:0]);
  assign enq_rdy     = rst_n && !full && !redir_vld && !flush_vld;
  assign enq_fire    = enq_vld && enq_rdy;
  assign bypass      = (fetch_q == tail_q) && enq_fire;
  assign fetch_vld   = ((fetch_q != tail_q) && !redir_vld && !flush_vld) || bypass;
  assign fetch_idx   = fetch_q[IDX_W-1:0];
  assign fetch_start = bypass ? enq_start : start_q[fetch_idx];
  assign fetch_next  = bypass ? enq_next : next_q[fetch_idx];
  assign fetch_fire  = fetch_vld && fetch_rdy;
  // redir_idx is known to sit in [head, tail), so it wraps past head iff its index is below head's.
  assign redir_ptr   = {head_q[IDX_W] ^ (redir_idx < head_q[IDX_W-1:0]), redir_idx};
  assign avail       = thre_q - head_q;
  assign win         = (avail < P_W'(CMT_W)) ? avail : P_W'(CMT_W);

  always_comb begin
    k = '0;
    stop = 1'b0;
    for (int j = 0; j < CMT_W; j++) begin
      stop = stop || (P_W'(j) >= win) || redir_q[head_q[IDX_W-1:0] + IDX_W'(j)];
      k = k + P_W'(!stop);
    end
  end

  assign upd_vld   = k < win;
  assign upd_idx   = head_q[IDX_W-1:0] + k[IDX_W-1:0];
  assign upd_start = start_q[upd_idx];
  assign upd_next  = next_q[upd_idx];
  assign upd_fire  = upd_vld && upd_rdy;
  assign adv       = k + P_W'(upd_fire);
  assign count     = count_q;
  assign rd_next   = rd_next_q;

  always_comb begin
    start_d = start_q;
    next_d  = next_q;
    vld_d   = vld_q;
    redir_d = redir_q;
    head_d  = head_q + adv;
    thre_d  = cmt_vld ? cmt_ptr_in : thre_q;
    tail_d  = flush_vld ? thre_q : redir_vld ? redir_ptr + P_W'(1) : tail_q + P_W'(enq_fire);
    fetch_d = flush_vld ? thre_q : redir_vld ? redir_ptr + P_W'(1) : fetch_q + P_W'(fetch_fire);
    for (int i = 0; i < DEPTH; i++) begin
      if (in_rng(head_q, head_q, head_d, IDX_W'(i))) begin
        vld_d[i]   = 1'b0;
        redir_d[i] = 1'b0;
      end
      if (flush_vld && in_rng(head_q, thre_q, tail_q, IDX_W'(i))) vld_d[i] = 1'b0;
      if (!flush_vld && redir_vld && in_rng(head_q, redir_ptr + P_W'(1), tail_q, IDX_W'(i))) vld_d[i] = 1'b0;
    end
    if (enq_fire) begin
      start_d[tail_q[IDX_W-1:0]] = enq_start;
      next_d[tail_q[IDX_W-1:0]]  = enq_next;
      vld_d[tail_q[IDX_W-1:0]]   = 1'b1;
      redir_d[tail_q[IDX_W-1:0]] = 1'b0;
    end
    if (redir_vld && !flush_vld) begin
      next_d[redir_idx]  = redir_npc;
      redir_d[redir_idx] = 1'b1;
    end
    count_d = tail_d - head_d;
    for (int p = 0; p < RD_PORTS; p++) rd_next_d[p] = next_q[rd_idx[p]];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tail_q    <= '0;
      fetch_q   <= '0;
      head_q    <= '0;
      thre_q    <= '0;
      vld_q     <= '0;
      redir_q   <= '0;
      count_q   <= '0;
      rd_next_q <= '0;
    end else begin
      tail_q    <= tail_d;
      fetch_q   <= fetch_d;
      head_q    <= head_d;
      thre_q    <= thre_d;
      vld_q     <= vld_d;
      redir_q   <= redir_d;
      count_q   <= count_d;
      rd_next_q <= rd_next_d;
    end

  always_ff @(posedge clk) begin
    start_q <= start_d;
    next_q  <= next_d;
  end

  assign cmt_span  = cmt_ptr_in - head_q;
  assign tail_span = tail_q - head_q;
  a_cmt_le_tail: assert property (@(posedge clk) disable iff (!rst_n) cmt_vld |-> (cmt_span <= tail_span));
endmodule

// File: tb/tb_ftq_gen2.sv
// tb_ftq_gen2: scoreboarded bench for ftq_gen2 at DEPTH=4, CMT_W=2.
module tb_ftq_gen2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enq_vld = 1'b0, enq_rdy;
  logic [63:0] enq_start = '0, enq_next = '0;
  logic fetch_vld, fetch_rdy = 1'b0;
  logic [1:0] fetch_idx;
  logic [63:0] fetch_start, fetch_next;
  logic redir_vld = 1'b0;
  logic [1:0] redir_idx = '0;
  logic [63:0] redir_npc = '0;
  logic flush_vld = 1'b0, cmt_vld = 1'b0;
  logic [2:0] cmt_ptr_in = '0;
  logic upd_vld, upd_rdy = 1'b0;
  logic [63:0] upd_start, upd_next;
  logic [1:0][1:0] rd_idx = '0;
  logic [1:0][63:0] rd_next;
  logic [2:0] count;

  typedef struct { logic [1:0] idx; logic [63:0] s; logic [63:0] n; } fe_t;
  typedef struct { logic [63:0] s; logic [63:0] n; } up_t;
  fe_t fq[$];
  up_t uq[$];
  fe_t fe;
  up_t ue;
  logic [1:0] te = '0, th = '0;
  logic [2:0] tp = '0;
  logic [63:0] es [4];
  logic [63:0] en [4];
  logic [63:0] old;
  int n_chk = 0, n_err = 0;

  ftq_gen2 #(.DEPTH(4), .ADDR_W(64), .RD_PORTS(2), .CMT_W(2)) dut (
    .clk(clk), .rst(rst), .enq_vld(enq_vld), .enq_rdy(enq_rdy), .enq_start(enq_start),
    .enq_next(enq_next), .fetch_vld(fetch_vld), .fetch_rdy(fetch_rdy), .fetch_idx(fetch_idx),
    .fetch_start(fetch_start), .fetch_next(fetch_next), .redir_vld(redir_vld),
    .redir_idx(redir_idx), .redir_npc(redir_npc), .flush_vld(flush_vld), .cmt_vld(cmt_vld),
    .cmt_ptr_in(cmt_ptr_in), .upd_vld(upd_vld), .upd_rdy(upd_rdy), .upd_start(upd_start),
    .upd_next(upd_next), .rd_idx(rd_idx), .rd_next(rd_next), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [63:0] s, input logic [63:0] n);
    enq_vld = 1'b1;
    enq_start = s;
    enq_next = n;
    es[tp[1:0]] = s;
    en[tp[1:0]] = n;
    tick();
    tp = tp + 3'd1;
    enq_vld = 1'b0;
    #1;
  endtask

  // Pending fetches are exactly the accepted enqueues not yet fetched; redirect and flush
  // both move fetch onto the new tail, so nothing stays pending across them.
  always @(negedge clk) begin
    if (!rst) begin
      fq.delete();
      uq.delete();
      te = '0;
      th = '0;
    end else begin
      if (flush_vld) begin
        fq.delete();
        te = th;
      end else if (redir_vld) begin
        fq.delete();
        te = redir_idx + 2'd1;
      end else begin
        if (enq_vld && enq_rdy) begin
          fq.push_back('{te, enq_start, enq_next});
          te = te + 2'd1;
        end
        if (fetch_vld && fetch_rdy) begin
          chk("fetch_pending", 64'(fq.size() > 0), 64'd1);
          if (fq.size() > 0) begin
            fe = fq.pop_front();
            chk("fetch_idx", 64'(fetch_idx), 64'(fe.idx));
            chk("fetch_start", fetch_start, fe.s);
            chk("fetch_next", fetch_next, fe.n);
          end
        end
      end
      if (cmt_vld) th = cmt_ptr_in[1:0];
      if (upd_vld && upd_rdy) begin
        chk("upd_pending", 64'(uq.size() > 0), 64'd1);
        if (uq.size() > 0) begin
          ue = uq.pop_front();
          chk("upd_start_sb", upd_start, ue.s);
          chk("upd_next_sb", upd_next, ue.n);
        end
      end
    end
  end

  initial begin
    repeat (3) tick();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_fetch_vld", 64'(fetch_vld), 64'd0);
    chk("rst_upd_vld", 64'(upd_vld), 64'd0);
    chk("rst_rd_next", rd_next[0], 64'd0);
    rst = 1'b1;
    repeat (3) tick();
    chk("enq_rdy_idle", 64'(enq_rdy), 64'd1);
    // same-cycle bypass into an empty queue
    fetch_rdy = 1'b1;
    enq_vld = 1'b1;
    enq_start = 64'h1000;
    enq_next = 64'h1010;
    es[0] = 64'h1000;
    en[0] = 64'h1010;
    #1;
    chk("byp_vld", 64'(fetch_vld), 64'd1);
    chk("byp_idx", 64'(fetch_idx), 64'd0);
    chk("byp_start", fetch_start, 64'h1000);
    tick();
    tp = 3'd1;
    enq_vld = 1'b0;
    #1;
    chk("byp_count", 64'(count), 64'd1);
    chk("byp_fetch_idle", 64'(fetch_vld), 64'd0);
    cmt_vld = 1'b1;
    cmt_ptr_in = 3'd1;
    tick();
    cmt_vld = 1'b0;
    tick();
    chk("retire1_count", 64'(count), 64'd0);
    // fill to full with fetch stalled
    fetch_rdy = 1'b0;
    for (int i = 0; i < 4; i++) enq(64'h3000 + 64'(i) * 64'h40, 64'h3020 + 64'(i) * 64'h40);
    chk("full_count", 64'(count), 64'd4);
    chk("full_enq_rdy", 64'(enq_rdy), 64'd0);
    chk("stall_vld", 64'(fetch_vld), 64'd1);
    chk("stall_idx", 64'(fetch_idx), 64'd1);
    enq_vld = 1'b1;
    enq_start = 64'hdead;
    tick();
    enq_vld = 1'b0;
    #1;
    chk("full_hold_count", 64'(count), 64'd4);
    chk("stall_start", fetch_start, es[1]);
    fetch_rdy = 1'b1;
    repeat (4) tick();
    cmt_vld = 1'b1;
    cmt_ptr_in = 3'd3;
    tick();
    cmt_vld = 1'b0;
    tick();
    chk("cmt2_count", 64'(count), 64'd2);
    chk("cmt2_enq_rdy", 64'(enq_rdy), 64'd1);
    // read-during-write on the entry being refilled returns the old next PC
    old = en[1];
    rd_idx[1] = 2'd1;
    enq(64'h4000, 64'h4040);
    chk("rdw_old", rd_next[1], old);
    enq(64'h4100, 64'h4140);
    chk("rdw_new", rd_next[1], en[1]);
    chk("live4_count", 64'(count), 64'd4);
    // redirect the second live entry (index 0)
    redir_vld = 1'b1;
    redir_idx = 2'd0;
    redir_npc = 64'h2000;
    uq.push_back('{es[0], 64'h2000});
    #1;
    chk("redir_enq_rdy", 64'(enq_rdy), 64'd0);
    chk("redir_fetch_vld", 64'(fetch_vld), 64'd0);
    tick();
    redir_vld = 1'b0;
    tp = 3'd5;
    rd_idx[0] = 2'd0;
    #1;
    chk("redir_count", 64'(count), 64'd2);
    chk("redir_tail", 64'(dut.tail_q), 64'd5);
    chk("redir_vld1", 64'(dut.vld_q[1]), 64'd0);
    chk("redir_vld2", 64'(dut.vld_q[2]), 64'd0);
    chk("redir_vld0", 64'(dut.vld_q[0]), 64'd1);
    tick();
    chk("redir_rd_next", rd_next[0], 64'h2000);
    // retire past the redirected entry with the update stalled
    enq(64'h4200, 64'h4240);
    chk("upd_pre_count", 64'(count), 64'd3);
    upd_rdy = 1'b0;
    cmt_vld = 1'b1;
    cmt_ptr_in = 3'd6;
    tick();
    cmt_vld = 1'b0;
    tick();
    chk("upd_vld_a", 64'(upd_vld), 64'd1);
    chk("upd_next_a", upd_next, 64'h2000);
    chk("upd_count_a", 64'(count), 64'd2);
    tick();
    chk("upd_vld_hold", 64'(upd_vld), 64'd1);
    chk("upd_next_hold", upd_next, 64'h2000);
    chk("upd_start_hold", upd_start, es[0]);
    upd_rdy = 1'b1;
    tick();
    chk("upd_count_b", 64'(count), 64'd1);
    tick();
    chk("upd_count_c", 64'(count), 64'd0);
    chk("upd_vld_done", 64'(upd_vld), 64'd0);
    // ten enqueue/retire pairs across the wrap boundary
    for (int i = 0; i < 10; i++) begin
      enq(64'h6000 + 64'(i) * 64'h20, 64'h6010 + 64'(i) * 64'h20);
      chk("wrap_tail_msb", 64'(dut.tail_q[2]), 64'(tp[2]));
      cmt_vld = 1'b1;
      cmt_ptr_in = tp;
      tick();
      cmt_vld = 1'b0;
      #1;
      chk("wrap_count_le4", 64'(count <= 3'd4), 64'd1);
    end
    repeat (2) tick();
    chk("wrap_count_end", 64'(count), 64'd0);
    // flush uncommitted entries back to the threshold
    for (int i = 0; i < 3; i++) enq(64'h7000 + 64'(i) * 64'h20, 64'h7010 + 64'(i) * 64'h20);
    chk("pre_flush_count", 64'(count), 64'd3);
    flush_vld = 1'b1;
    enq_vld = 1'b1;
    #1;
    chk("flush_enq_rdy", 64'(enq_rdy), 64'd0);
    chk("flush_fetch_vld", 64'(fetch_vld), 64'd0);
    tick();
    flush_vld = 1'b0;
    enq_vld = 1'b0;
    tp = tp - 3'd3;
    #1;
    chk("flush_tail", 64'(dut.tail_q), 64'(tp));
    chk("flush_fetch", 64'(dut.fetch_q), 64'(tp));
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_vld_bits", 64'(dut.vld_q), 64'd0);
    // reset while a fetch is pending
    fetch_rdy = 1'b0;
    enq(64'h8000, 64'h8010);
    enq(64'h8100, 64'h8110);
    chk("pre_rst_fetch_vld", 64'(fetch_vld), 64'd1);
    rst = 1'b0;
    #1;
    chk("rst_fetch_now", 64'(fetch_vld), 64'd0);
    chk("rst_count_now", 64'(count), 64'd0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
    chk("post_rst_enq_rdy", 64'(enq_rdy), 64'd1);
    tp = '0;
    fetch_rdy = 1'b1;
    enq_vld = 1'b1;
    enq_start = 64'h5000;
    enq_next = 64'h5010;
    #1;
    chk("post_rst_idx", 64'(fetch_idx), 64'd0);
    chk("post_rst_start", fetch_start, 64'h5000);
    tick();
    enq_vld = 1'b0;
    #1;
    chk("post_rst_count", 64'(count), 64'd1);
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ftq_gen2.md
FTQ_GEN2 -- requirements
Module: ftq_gen2

Interface
REQ-001 DEPTH, 16, queue entries; power of 2, >=4; IDX_W = log2(DEPTH).
REQ-002 ADDR_W, 64, PC width.
REQ-003 RD_PORTS, 2, backend read ports.
REQ-004 CMT_W, 2, max entries retired per cycle, 1..DEPTH.
REQ-005 clk  input  1  clock, rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 enq_vld  input  1  BPU prediction valid.
REQ-008 enq_rdy  output  1  queue accepts prediction.
REQ-009 enq_start  input  ADDR_W  fetch block start PC.
REQ-010 enq_next  input  ADDR_W  predicted next PC.
REQ-011 fetch_vld  output  1  icache request valid.
REQ-012 fetch_rdy  input  1  icache accepts request.
REQ-013 fetch_idx  output  IDX_W  entry index of request.
REQ-014 fetch_start  output  ADDR_W  request start PC.
REQ-015 fetch_next  output  ADDR_W  request next PC.
REQ-016 redir_vld  input  1  predecode redirect.
REQ-017 redir_idx  input  IDX_W  redirected entry.
REQ-018 redir_npc  input  ADDR_W  corrected next PC.
REQ-019 flush_vld  input  1  backend squash.
REQ-020 cmt_vld  input  1  commit threshold update.
REQ-021 cmt_ptr_in  input  IDX_W+1  new threshold pointer incl. wrap bit.
REQ-022 upd_vld  output  1  BPU update request.
REQ-023 upd_rdy  input  1  BPU update accepted.
REQ-024 upd_start / upd_next  output  ADDR_W each  update payload.
REQ-025 rd_idx  input  RD_PORTS x IDX_W  backend read indices.
REQ-026 rd_next  output  RD_PORTS x ADDR_W  entry next PC.
REQ-027 count  output  IDX_W+1  occupied entries.

Function
REQ-028 Storage: DEPTH entries {start, next, vld, redir}; pointers tail, fetch, head, thre each IDX_W+1 bits (MSB = wrap bit, increment mod 2*DEPTH).
REQ-029 full = tail/head index equal, wrap differ; empty = tail == head; enq_rdy = !full && !redir_vld && !flush_vld, combinational.
REQ-030 Enqueue on enq_vld && enq_rdy: entry[tail] <= {enq_start, enq_next, vld=1, redir=0}; tail+1 next edge.
REQ-031 fetch_vld = (fetch != tail) || bypass; bypass = (fetch == tail) && enq_vld && enq_rdy, driving fetch_start/next from enq_* and fetch_idx = tail index same cycle.
REQ-032 fetch advances by 1 on fetch_vld && fetch_rdy; fetch outputs stay stable while fetch_vld && !fetch_rdy unless redirect/flush.
REQ-033 Redirect (redir_vld, !flush_vld): redir_idx lies in [head, tail); entry.next <= redir_npc, entry.redir <= 1; tail and fetch <= redir pointer + 1 (wrap bit reconstructed relative to head); younger entries vld <= 0; no enqueue/fetch handshake that cycle.
REQ-034 Flush (priority over redirect): tail, fetch <= registered thre; entries in [thre, tail) vld <= 0; all other actions except commit suppressed.
REQ-035 cmt_vld: thre <= cmt_ptr_in next edge; cmt_ptr_in never passes tail (assertion).
REQ-036 Retire window W = min(CMT_W, thre - head); k = leading entries in window with redir=0.
REQ-037 upd_vld = k < W; upd_start/next = entry[head+k]; upd_* stable until upd_rdy.
REQ-038 head advances by k + (upd_vld && upd_rdy); retired entries vld <= 0, same edge.
REQ-039 Simultaneous enqueue at full with retire: enq_rdy still 0 (no bypass of full).
REQ-040 rd_next[p] <= entry[rd_idx[p]].next; one-cycle latency, read-during-write returns old value.
REQ-041 count <= tail - head (mod 2*DEPTH), registered, updated every edge.

Reset
REQ-042 rst low: all pointers and wrap bits 0, all vld/redir 0, count 0, rd_next 0, upd_vld 0; fetch_vld 0 unless bypass; entry PCs not reset; rst release synchronised to clk edge.

Verification (DEPTH=4, CMT_W=2)
REQ-043 Empty, enq_vld, enq_start=0x1000, fetch_rdy=1 -> same-cycle fetch_vld=1, fetch_idx=0, fetch_start=0x1000; next cycle count=1.
REQ-044 4 enqueues, fetch_rdy=0 -> enq_rdy=0, count=4; cmt_ptr_in=2 -> next cycle head=2, count=2, enq_rdy=1.
REQ-045 Entries 0..3 live, redir_idx=1, redir_npc=0x2000 -> tail=2, count=2, entry1.next=0x2000, entries 2,3 invalid.
REQ-046 Entry1 redirected, thre=3, upd_rdy=0 -> entry0 retires, upd_vld=1, upd_next=0x2000 holds; upd_rdy=1 -> head=2.
REQ-047 Wrap: 10 enqueue/retire pairs -> tail wrap bit toggles every 4, count never exceeds 4; flush mid-stream -> tail=fetch=thre; rst low mid-fetch -> fetch_vld=0 immediately.
